// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: PC source selects, fetch
// states, opcodes, and the jump-target helper.
package mips_pkg;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Pseudo-direct jump: keep the PC's 256 MB region, word-align the index.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                              input logic [25:0] idx);
    return {pc_hi, idx, 2'b00};
  endfunction
endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select; shared with a future pipelined front end.
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc,
  input  logic [25:0] jump_idx,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  output logic [31:0] next_pc
);
  always_comb begin
    next_pc = pc;
    case (pc_src)
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = jump_target(pc[31:28], jump_idx);
      default:      next_pc = pc;
    endcase
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs the req/ack memory handshake with a
// timeout, and applies control-unit PC updates every cycle.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err
);
  fetch_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      next_pc;
  logic             pc_en;

  pc_next_mux u_pc_next_mux (
    .pc_src     (pc_src),
    .pc         (pc),
    .jump_idx   (instr[25:0]),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .next_pc    (next_pc)
  );

  assign pc_en  = pc_write | (branch & zero);
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign busy   = (state != FS_IDLE);

  // PC updates are independent of the fetch FSM; mem_addr holds its own copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pc <= RESET_PC;
    else if (pc_en) pc <= next_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FS_IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      instr      <= '0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        FS_IDLE: if (fetch_req) begin
          mem_addr  <= pc;
          mem_req   <= 1'b1;
          cnt       <= '0;
          fetch_err <= 1'b0;
          state     <= FS_REQ;
        end
        // Ack is checked first so it wins over a coincident timeout.
        FS_REQ: if (mem_ack) begin
          instr      <= mem_rdata;
          mem_req    <= 1'b0;
          fetch_done <= 1'b1;
          state      <= FS_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          mem_req   <= 1'b0;
          fetch_err <= 1'b1;
          state     <= FS_IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        FS_DONE: state <= FS_IDLE;
        default: state <= FS_IDLE;
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage of the multicycle MIPS core. It owns the PC and the instruction register (IR).
- When the control unit asks for a fetch, it runs a req/ack handshake with the shared memory and latches the returned word. It then presents opcode/funct to the control unit and ALU decoder.
- It also applies PC updates (PC+4, branch, jump) from the control unit's PCWrite/Branch/PCSrc signals.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before abort (must be >=2).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_req  input  1  one-cycle request from control unit (FETCH state).
- pc_write  input  1  unconditional PC update enable.
- branch  input  1  conditional PC update enable.
- zero  input  1  ALU zero flag.
- pc_src  input  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 hold.
- alu_result  input  32  combinational ALU output.
- alu_out  input  32  registered ALU output.
- mem_rdata  input  32  memory read data, valid when mem_ack=1.
- mem_ack  input  1  memory completion strobe.
- mem_req  output  1  memory read request.
- mem_addr  output  32  memory address, stable while mem_req=1.
- pc  output  32  current PC.
- instr  output  32  instruction register contents.
- opcode  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- fetch_done  output  1  one-cycle pulse: IR freshly loaded.
- busy  output  1  fetch in progress (state != IDLE).
- fetch_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, instr=0, mem_req=0, mem_addr=0, fetch_done=0, fetch_err=0, state=IDLE, counter=0. A reset during REQ drops mem_req at once; no IR write occurs.
- State machine IDLE -> REQ -> DONE -> IDLE.
- IDLE:
  - fetch_req=1 at edge N: mem_addr<=pc (sampled at N), mem_req<=1, counter<=0, fetch_err<=0, state<=REQ.
- REQ: mem_req=1, mem_addr held.
  - mem_ack=1 at edge: instr<=mem_rdata, mem_req<=0, state<=DONE.
  - Else counter++. When counter reaches TIMEOUT-1 with no ack: mem_req<=0, fetch_err<=1, state<=IDLE, IR unchanged.
  - mem_ack on the same edge as the timeout wins (data accepted, no error).
- DONE: fetch_done=1 for exactly one cycle, then IDLE.
  - A fetch_req in DONE is ignored.
- fetch_req while busy is ignored (no queueing).
- mem_ack outside REQ is ignored.
- Latency: fetch_req at cycle N -> mem_req high cycle N+1. Ack sampled at cycle M -> instr/fetch_done valid cycle M+1. Minimum 3 cycles request-to-done (ack in N+1).
- PC update, evaluated every edge independent of fetch state: pc_en = pc_write | (branch & zero).
  - If pc_en, pc <= next_pc.
  - next_pc = alu_result (00), alu_out (01), {pc[31:28], instr[25:0], 2'b00} (10), pc (11).
- A PC update during REQ does not affect mem_addr (already latched).
- Arithmetic: jump target uses the current pc upper nibble. No overflow handling; the PC wraps naturally at 32 bits. pc[1:0] is not forced to zero.
- opcode/funct are combinational slices of instr.

Decomposition:
- Shared package mips_pkg holds:
  - PCSrc encodings (PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10).
  - Fetch state encoding (FS_IDLE, FS_REQ, FS_DONE).
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), reused by the control unit.
- One natural sub-module: pc_next_mux, a combinational next-PC select plus jump-target build, also usable by a future pipelined variant.

Test Plan:
- Reset then fetch_req at cycle 2, mem_rdata=32'h2008_0005, mem_ack in cycle 3: mem_addr=0 in cycle 3, instr=32'h2008_0005, opcode=6'h08, fetch_done=1 in cycle 4 only, busy=0 in cycle 5.
- pc_write=1, pc_src=00, alu_result=32'h4: pc=32'h4 next cycle. Then branch=1, zero=0: pc unchanged. Then zero=1, pc_src=01, alu_out=32'h40: pc=32'h40.
- Jump with pc=32'h3000_0010, instr=32'h0800_0100, pc_src=10, pc_write=1: pc=32'h3000_0400.
- No ack for TIMEOUT=16 cycles: mem_req falls after 16 REQ cycles, fetch_err=1, instr unchanged. The next fetch_req clears fetch_err and a normal fetch completes.
- fetch_req pulsed again during REQ and during DONE: no second mem_req, exactly one fetch_done. pc_write in REQ changes pc but mem_addr stays at the original value.
- reset asserted mid-REQ (asynchronous, between edges): mem_req=0 immediately, pc=RESET_PC, a late mem_ack after deassertion is ignored, fetch_done never pulses.
